pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between two processor stages (control bundle + data lanes).
// Define PIPE_STAGE_REG_SKID_EN for the two-entry skid build; otherwise single entry.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32,
  parameter int LANES  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic [LANES*DATA_W-1:0] data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [LANES*DATA_W-1:0] data_o,
  output logic [15:0]             stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                    state, state_n;
  logic                      rdy_p0, rdy_n;
  logic [CTRL_W-1:0]         ctrl_p0, ctrl_p1;
  logic [LANES*DATA_W-1:0]   data_p0, data_p1;
  logic                      accept, deliver;
  logic                      load_main, load_skid, move_skid;
  logic [15:0]               stall_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign valid_o     = (state != EMPTY);
  assign ctrl_o      = ctrl_p0;
  assign data_o      = data_p0;
  assign stall_cnt_o = stall_cnt;

`ifdef PIPE_STAGE_REG_SKID_EN
  assign ready_o = rdy_p0;
`else
  // rdy_p0 only masks ready_o until the first edge after reset
  assign ready_o = rdy_p0 & (ready_i | ~valid_o);
`endif

  assign accept  = valid_i & ready_o;
  assign deliver = valid_o & ready_i;

  always_comb begin
    state_n   = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_n   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
`ifdef PIPE_STAGE_REG_SKID_EN
        if (accept && deliver) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_n   = TWO;
          load_skid = 1'b1;
        end else if (deliver) begin
          state_n = EMPTY;
        end
`else
        if (accept) begin
          load_main = 1'b1;
        end else if (deliver) begin
          state_n = EMPTY;
        end
`endif
      end
      TWO: begin
        if (deliver) begin
          state_n   = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
    if (flush_i) begin
      state_n   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  assign rdy_n = (state_n != TWO);
`else
  assign rdy_n = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= EMPTY;
      rdy_p0    <= 1'b0;
      ctrl_p0   <= '0;
      ctrl_p1   <= '0;
      data_p0   <= '0;
      data_p1   <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_n;
      rdy_p0 <= rdy_n;
      if (valid_o && !ready_i) stall_cnt <= sat_inc16(stall_cnt);
      // main register: clearing ctrl whenever the stage empties keeps bubbles all-zero
      if (load_main) begin
        ctrl_p0 <= ctrl_i;
        data_p0 <= data_i;
      end else if (move_skid) begin
        ctrl_p0 <= ctrl_p1;
        data_p0 <= data_p1;
      end else if (state_n == EMPTY) begin
        ctrl_p0 <= '0;
      end
      if (load_skid) begin
        ctrl_p1 <= ctrl_i;
        data_p1 <= data_i;
      end else if (flush_i || move_skid) begin
        ctrl_p1 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg: queue-based reference model of an elastic stage.
// Follows the PIPE_STAGE_REG_SKID_EN setting of the build (capacity 2 vs 1).
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk, rst_n, flush, valid_in, ready_out, valid_out, ready_in;
  logic [7:0]   ctrl_in, ctrl_out;
  logic [127:0] data_in, data_out;
  logic [15:0]  stall_cnt;

  typedef struct packed {
    logic [7:0]   c;
    logic [127:0] d;
  } entry_t;

  entry_t q[$];
  bit     init;
  int     stall_m;
  int     n_vec, n_err;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .LANES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(valid_in),
    .ready_o(ready_out), .ctrl_i(ctrl_in), .data_i(data_in), .valid_o(valid_out),
    .ready_i(ready_in), .ctrl_o(ctrl_out), .data_o(data_out), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; flush = 1'b0;
    #1;
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_ready", ready_out, 0);
    check_eq("rst_ctrl", ctrl_out, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_stall", stall_cnt, 0);
    q.delete();
    stall_m = 0;
    init = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic cycle(input logic v, input logic r, input logic f,
                       input logic [7:0] c, input logic [127:0] d);
    logic rdy_exp, acc, dlv;
    entry_t e;
    @(negedge clk);
    valid_in = v; ready_in = r; flush = f; ctrl_in = c; data_in = d;
    #1;
    rdy_exp = init && (SKID ? (q.size() < 2) : (q.size() == 0 || r));
    check_eq("valid_o", valid_out, q.size() != 0);
    check_eq("ready_o", ready_out, rdy_exp);
    if (q.size() != 0) begin
      check_eq("ctrl_o", ctrl_out, q[0].c);
      check_eq("data_o", data_out, q[0].d);
    end else begin
      check_eq("ctrl_bubble", ctrl_out, 0);
    end
    check_eq("stall_cnt", stall_cnt, stall_m);
    acc = v && rdy_exp;
    dlv = (q.size() != 0) && r;
    if (q.size() != 0 && !r && stall_m < 65535) stall_m++;
    if (f) begin
      q.delete();
    end else begin
      if (dlv) void'(q.pop_front());
      if (acc) begin
        e.c = c;
        e.d = d;
        q.push_back(e);
      end
    end
    @(posedge clk);
    init = 1'b1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    n_vec = 0; n_err = 0; init = 1'b0; stall_m = 0;
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    ctrl_in = '0; data_in = '0;
    do_reset();

    // continuous stream, data 0,1,2,...
    cycle(1'b0, 1'b1, 1'b0, 8'h00, '0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 8'(i + 1), 128'(i));
    cycle(1'b0, 1'b1, 1'b0, 8'h00, '0);

    // ignored control while not valid
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'hFF, rnd128());

    // back-pressure with a second entry offered
    cycle(1'b1, 1'b1, 1'b0, 8'h11, 128'hA);
    cycle(1'b1, 1'b0, 1'b0, 8'h22, 128'hB);
    cycle(1'b1, 1'b0, 1'b0, 8'h99, 128'h9);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, '0);

    // flush while full, with an entry offered
    cycle(1'b1, 1'b0, 1'b0, 8'h33, 128'hC);
    cycle(1'b1, 1'b0, 1'b0, 8'h44, 128'hD);
    cycle(1'b1, 1'b0, 1'b1, 8'h55, 128'hE);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, '0);

    // random traffic
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0), 8'($urandom), rnd128());

    // reset in the middle of a transfer
    cycle(1'b1, 1'b0, 1'b0, 8'h66, 128'h66);
    cycle(1'b1, 1'b0, 1'b0, 8'h77, 128'h77);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, '0);

    // stall counter saturation, survives flush, cleared by async reset
    cycle(1'b1, 1'b0, 1'b0, 8'h5A, 128'h5A);
    for (int i = 0; i < 65600; i++) begin
      @(negedge clk);
      valid_in = 1'b0; ready_in = 1'b0; flush = 1'b0;
      if (stall_m < 65535) stall_m++;
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, '0);
    cycle(1'b1, 1'b0, 1'b1, 8'h12, 128'h12);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, '0);
    check_eq("stall_after_flush", stall_cnt, 16'hFFFF);
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 8'h00, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
